// File: rtl/pixel_stream_arbiter.sv
// Round-robin, burst-locked arbiter merging four RGB pixel streams onto one
// registered output port. A grant is held from the first beat of a burst
// until its last beat, so bursts from different sources never interleave.
module pixel_stream_arbiter #(
  parameter int unsigned CH_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH_WIDTH-1:0] in1_r,
  input  logic [CH_WIDTH-1:0] in1_g,
  input  logic [CH_WIDTH-1:0] in1_b,
  input  logic                in1_last,
  input  logic                in1_valid,
  output logic                in1_ready,
  input  logic [CH_WIDTH-1:0] in2_r,
  input  logic [CH_WIDTH-1:0] in2_g,
  input  logic [CH_WIDTH-1:0] in2_b,
  input  logic                in2_last,
  input  logic                in2_valid,
  output logic                in2_ready,
  input  logic [CH_WIDTH-1:0] in3_r,
  input  logic [CH_WIDTH-1:0] in3_g,
  input  logic [CH_WIDTH-1:0] in3_b,
  input  logic                in3_last,
  input  logic                in3_valid,
  output logic                in3_ready,
  input  logic [CH_WIDTH-1:0] in4_r,
  input  logic [CH_WIDTH-1:0] in4_g,
  input  logic [CH_WIDTH-1:0] in4_b,
  input  logic                in4_last,
  input  logic                in4_valid,
  output logic                in4_ready,
  output logic [CH_WIDTH-1:0] out_port_r,
  output logic [CH_WIDTH-1:0] out_port_g,
  output logic [CH_WIDTH-1:0] out_port_b,
  output logic                out_port_last,
  output logic                out_port_valid,
  input  logic                out_port_ready,
  output logic [3:0]          grant
);

  localparam int unsigned PORTS   = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t               state, state_n;
  logic [PORTS-1:0]     grant_n;
  logic [IDX_W-1:0]     rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0]     winner;
  logic                 accept;
  logic [CH_WIDTH-1:0]  out_r_n, out_g_n, out_b_n;
  logic                 out_last_n, out_valid_n;

  logic [CH_WIDTH-1:0]  r_vec [PORTS];
  logic [CH_WIDTH-1:0]  g_vec [PORTS];
  logic [CH_WIDTH-1:0]  b_vec [PORTS];
  logic [PORTS-1:0]     valid_vec, last_vec, ready_vec;

  // Gather requester ports into indexable vectors.
  assign r_vec[0] = in1_r;  assign g_vec[0] = in1_g;  assign b_vec[0] = in1_b;
  assign r_vec[1] = in2_r;  assign g_vec[1] = in2_g;  assign b_vec[1] = in2_b;
  assign r_vec[2] = in3_r;  assign g_vec[2] = in3_g;  assign b_vec[2] = in3_b;
  assign r_vec[3] = in4_r;  assign g_vec[3] = in4_g;  assign b_vec[3] = in4_b;
  assign valid_vec = {in4_valid, in3_valid, in2_valid, in1_valid};
  assign last_vec  = {in4_last, in3_last, in2_last, in1_last};

  // Owner may push whenever the output register is empty or draining; grant is
  // zero while idle, so nobody is ready then.
  assign ready_vec = grant & {PORTS{~out_port_valid | out_port_ready}};
  assign in1_ready = ready_vec[0];
  assign in2_ready = ready_vec[1];
  assign in3_ready = ready_vec[2];
  assign in4_ready = ready_vec[3];

  // While granted, rr_ptr holds the owner index, so it doubles as the data select.
  assign accept = |(valid_vec & ready_vec);

  // Round-robin search starting one past the last winner, wrapping 4 -> 1.
  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             found;
    winner = rr_ptr;
    found  = 1'b0;
    idx    = rr_ptr;
    for (int i = 1; i <= int'(PORTS); i++) begin
      idx = rr_ptr + IDX_W'(i);
      if (!found && valid_vec[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Next-state, grant, pointer and output-register update.
  always_comb begin
    state_n     = state;
    grant_n     = grant;
    rr_ptr_n    = rr_ptr;
    out_r_n     = out_port_r;
    out_g_n     = out_port_g;
    out_b_n     = out_port_b;
    out_last_n  = out_port_last;
    out_valid_n = out_port_valid;

    case (state)
      IDLE: begin
        if (|valid_vec) begin
          state_n  = GRANTED;
          grant_n  = PORTS'(1) << winner;
          rr_ptr_n = winner;
        end
      end
      GRANTED: begin
        if (accept && last_vec[rr_ptr]) begin
          state_n = IDLE;
          grant_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase

    if (accept) begin
      out_r_n     = r_vec[rr_ptr];
      out_g_n     = g_vec[rr_ptr];
      out_b_n     = b_vec[rr_ptr];
      out_last_n  = last_vec[rr_ptr];
      out_valid_n = 1'b1;
    end else if (out_port_ready) begin
      out_valid_n = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      grant          <= '0;
      rr_ptr         <= IDX_W'(PORTS - 1);
      out_port_r     <= '0;
      out_port_g     <= '0;
      out_port_b     <= '0;
      out_port_last  <= 1'b0;
      out_port_valid <= 1'b0;
    end else begin
      state          <= state_n;
      grant          <= grant_n;
      rr_ptr         <= rr_ptr_n;
      out_port_r     <= out_r_n;
      out_port_g     <= out_g_n;
      out_port_b     <= out_b_n;
      out_port_last  <= out_last_n;
      out_port_valid <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_pixel_stream_arbiter.sv
// Directed bench for pixel_stream_arbiter: reset, single burst, fairness,
// backpressure, non-owner isolation, mid-burst reset and single-beat bursts.
module tb_pixel_stream_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_r [4];
  logic [7:0] in_g [4];
  logic [7:0] in_b [4];
  logic [3:0] in_last;
  logic [3:0] in_valid;
  wire  [3:0] rdy;
  wire  [7:0] out_r, out_g, out_b;
  wire        out_last, out_valid;
  logic       out_ready;
  wire  [3:0] grant;

  int n_cmp = 0;
  int n_err = 0;

  pixel_stream_arbiter #(.CH_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in1_r(in_r[0]), .in1_g(in_g[0]), .in1_b(in_b[0]), .in1_last(in_last[0]),
    .in1_valid(in_valid[0]), .in1_ready(rdy[0]),
    .in2_r(in_r[1]), .in2_g(in_g[1]), .in2_b(in_b[1]), .in2_last(in_last[1]),
    .in2_valid(in_valid[1]), .in2_ready(rdy[1]),
    .in3_r(in_r[2]), .in3_g(in_g[2]), .in3_b(in_b[2]), .in3_last(in_last[2]),
    .in3_valid(in_valid[2]), .in3_ready(rdy[2]),
    .in4_r(in_r[3]), .in4_g(in_g[3]), .in4_b(in_b[3]), .in4_last(in_last[3]),
    .in4_valid(in_valid[3]), .in4_ready(rdy[3]),
    .out_port_r(out_r), .out_port_g(out_g), .out_port_b(out_b),
    .out_port_last(out_last), .out_port_valid(out_valid),
    .out_port_ready(out_ready), .grant(grant)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive port k; g and b are derived from r so one value identifies a beat.
  task automatic set_port(input int k, input bit v, input logic [7:0] r, input bit l);
    in_valid[k] = v;
    in_r[k]     = r;
    in_g[k]     = r + 8'h10;
    in_b[k]     = r + 8'h20;
    in_last[k]  = l;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) set_port(k, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got %b want 0000", grant); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (rdy !== 4'b0000) begin n_err++; $display("FAIL reset_ready got %b want 0000", rdy); end
    n_cmp++; if ({out_r, out_g, out_b, out_last} !== 25'd0) begin n_err++; $display("FAIL reset_payload got %h/%h/%h/%b want zeros", out_r, out_g, out_b, out_last); end
  endtask

  task automatic test_single();
    do_reset();
    set_port(1, 1'b1, 8'h10, 1'b0);
    #1;
    n_cmp++; if (rdy !== 4'b0000) begin n_err++; $display("FAIL single_idle_ready got %b want 0000", rdy); end
    tick();
    n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL single_grant got %b want 0010", grant); end
    n_cmp++; if (rdy !== 4'b0010) begin n_err++; $display("FAIL single_ready got %b want 0010", rdy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got %b want 0", out_valid); end
    tick();
    n_cmp++; if ({out_valid, out_r, out_g, out_b, out_last} !== {1'b1, 8'h10, 8'h20, 8'h30, 1'b0}) begin
      n_err++; $display("FAIL single_beat0 got v=%b %h/%h/%h l=%b want v=1 10/20/30 l=0", out_valid, out_r, out_g, out_b, out_last); end
    set_port(1, 1'b1, 8'h11, 1'b0);
    tick();
    n_cmp++; if ({out_valid, out_r, out_g, out_b, out_last} !== {1'b1, 8'h11, 8'h21, 8'h31, 1'b0}) begin
      n_err++; $display("FAIL single_beat1 got v=%b %h/%h/%h l=%b want v=1 11/21/31 l=0", out_valid, out_r, out_g, out_b, out_last); end
    set_port(1, 1'b1, 8'h12, 1'b1);
    tick();
    n_cmp++; if ({out_valid, out_r, out_g, out_b, out_last} !== {1'b1, 8'h12, 8'h22, 8'h32, 1'b1}) begin
      n_err++; $display("FAIL single_beat2 got v=%b %h/%h/%h l=%b want v=1 12/22/32 l=1", out_valid, out_r, out_g, out_b, out_last); end
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL single_release got %b want 0000", grant); end
    set_port(1, 1'b0, 8'h00, 1'b0);
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", out_valid); end
  endtask

  task automatic test_fairness();
    int         beat [4];
    logic [3:0] acc;
    int         j, ph;
    logic [3:0] e_grant;
    logic [7:0] e_r;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      beat[k] = 0;
      set_port(k, 1'b1, 8'(16 * (k + 1)), 1'b0);
    end
    for (int c = 1; c <= 13; c++) begin
      #1;
      acc = rdy & in_valid;
      tick();
      for (int k = 0; k < 4; k++)
        if (acc[k]) begin
          beat[k]++;
          set_port(k, 1'b1, 8'(16 * (k + 1) + beat[k]), (beat[k] % 2) == 1);
        end
      j  = (c - 1) / 3;
      ph = (c - 1) % 3;
      e_grant = (ph == 2) ? 4'b0000 : (4'b0001 << (j % 4));
      e_r     = 8'(16 * (j % 4 + 1) + 2 * (j / 4) + ((ph == 2) ? 1 : 0));
      n_cmp++; if (grant !== e_grant) begin n_err++; $display("FAIL fair_grant c=%0d got %b want %b", c, grant, e_grant); end
      n_cmp++; if (out_valid !== (ph != 0)) begin n_err++; $display("FAIL fair_valid c=%0d got %b want %b", c, out_valid, ph != 0); end
      if (ph != 0) begin
        n_cmp++; if ({out_r, out_last} !== {e_r, ph == 2}) begin
          n_err++; $display("FAIL fair_data c=%0d got %h l=%b want %h l=%b", c, out_r, out_last, e_r, ph == 2); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit   ordy_t [8] = '{0, 1, 0, 0, 1, 1, 1, 1};
    int   beat_t [8] = '{0, 1, 2, 2, 2, 3, -1, -1};
    bit   rdy_t  [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    bit   ov_t   [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] r_t [8] = '{8'h00, 8'h40, 8'h41, 8'h41, 8'h41, 8'h42, 8'h43, 8'h00};
    do_reset();
    set_port(0, 1'b1, 8'h40, 1'b0);
    tick();
    for (int c = 0; c < 8; c++) begin
      n_cmp++; if (out_valid !== ov_t[c]) begin n_err++; $display("FAIL bp_valid c=%0d got %b want %b", c + 1, out_valid, ov_t[c]); end
      if (ov_t[c]) begin
        n_cmp++; if ({out_r, out_g, out_last} !== {r_t[c], r_t[c] + 8'h10, c == 6}) begin
          n_err++; $display("FAIL bp_data c=%0d got %h/%h l=%b want %h/%h l=%b", c + 1, out_r, out_g, out_last, r_t[c], r_t[c] + 8'h10, c == 6); end
      end
      n_cmp++; if (grant !== ((c < 6) ? 4'b0001 : 4'b0000)) begin n_err++; $display("FAIL bp_grant c=%0d got %b", c + 1, grant); end
      out_ready = ordy_t[c];
      if (beat_t[c] >= 0) set_port(0, 1'b1, 8'(8'h40 + beat_t[c]), beat_t[c] == 3);
      else                set_port(0, 1'b0, 8'h00, 1'b0);
      #1;
      n_cmp++; if (rdy !== {3'b000, rdy_t[c]}) begin n_err++; $display("FAIL bp_ready c=%0d got %b want %b", c + 1, rdy, rdy_t[c]); end
      tick();
    end
  endtask

  task automatic test_isolation();
    logic [3:0] g_t   [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0000};
    bit         ov_t  [6] = '{0, 1, 1, 1, 0, 1};
    logic [7:0] r_t   [6] = '{8'h00, 8'h60, 8'h61, 8'h62, 8'h00, 8'hB3};
    bit         l_t   [6] = '{0, 0, 0, 1, 0, 1};
    logic [3:0] rdy_t [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0000};
    do_reset();
    set_port(0, 1'b1, 8'h60, 1'b0);
    set_port(2, 1'b1, 8'hA0, 1'b0);
    tick();
    for (int c = 0; c < 6; c++) begin
      n_cmp++; if (grant !== g_t[c]) begin n_err++; $display("FAIL iso_grant c=%0d got %b want %b", c + 1, grant, g_t[c]); end
      n_cmp++; if (out_valid !== ov_t[c]) begin n_err++; $display("FAIL iso_valid c=%0d got %b want %b", c + 1, out_valid, ov_t[c]); end
      if (ov_t[c]) begin
        n_cmp++; if ({out_r, out_last} !== {r_t[c], l_t[c]}) begin
          n_err++; $display("FAIL iso_data c=%0d got %h l=%b want %h l=%b", c + 1, out_r, out_last, r_t[c], l_t[c]); end
      end
      if (c <= 2) set_port(0, 1'b1, 8'(8'h60 + c), c == 2);
      else        set_port(0, 1'b0, 8'h00, 1'b0);
      if (c <= 2)      set_port(2, 1'b1, 8'(8'hA1 + c), 1'b0);
      else if (c <= 4) set_port(2, 1'b1, 8'hB3, 1'b1);
      else             set_port(2, 1'b0, 8'h00, 1'b0);
      #1;
      n_cmp++; if (rdy !== rdy_t[c]) begin n_err++; $display("FAIL iso_ready c=%0d got %b want %b", c + 1, rdy, rdy_t[c]); end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b0;
    set_port(3, 1'b1, 8'h70, 1'b0);
    tick();
    n_cmp++; if ({grant, rdy} !== {4'b1000, 4'b1000}) begin n_err++; $display("FAIL mrst_grant got %b/%b want 1000/1000", grant, rdy); end
    tick();
    set_port(3, 1'b1, 8'h71, 1'b0);
    #1;
    n_cmp++; if ({out_valid, out_r, rdy} !== {1'b1, 8'h70, 4'b0000}) begin
      n_err++; $display("FAIL mrst_stall got v=%b r=%h rdy=%b want v=1 r=70 rdy=0000", out_valid, out_r, rdy); end
    rst = 1'b1;
    set_port(0, 1'b1, 8'h80, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if ({out_valid, grant, rdy, out_r, out_last} !== 18'd0) begin
      n_err++; $display("FAIL mrst_after got v=%b g=%b rdy=%b r=%h l=%b want all zero", out_valid, grant, rdy, out_r, out_last); end
    tick();
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL mrst_rearb got %b want 0001", grant); end
  endtask

  task automatic test_single_beat();
    int         n [2];
    logic [3:0] acc;
    int         p;
    logic [7:0] e_r;
    do_reset();
    n[0] = 0;
    n[1] = 0;
    set_port(0, 1'b1, 8'h10, 1'b1);
    set_port(1, 1'b1, 8'h20, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      #1;
      acc = rdy & in_valid;
      tick();
      for (int k = 0; k < 2; k++)
        if (acc[k]) begin
          n[k]++;
          set_port(k, 1'b1, 8'(16 * (k + 1) + n[k]), 1'b1);
        end
      if (c % 2 == 1) begin
        n_cmp++; if ({grant, out_valid} !== {((c % 4 == 1) ? 4'b0001 : 4'b0010), 1'b0}) begin
          n_err++; $display("FAIL sb_grant c=%0d got g=%b v=%b", c, grant, out_valid); end
      end else begin
        p   = ((c / 2) - 1) % 2;
        e_r = 8'(16 * (p + 1) + (c - 2) / 4);
        n_cmp++; if ({grant, out_valid, out_r, out_last} !== {4'b0000, 1'b1, e_r, 1'b1}) begin
          n_err++; $display("FAIL sb_beat c=%0d got g=%b v=%b r=%h l=%b want g=0000 v=1 r=%h l=1", c, grant, out_valid, out_r, out_last, e_r); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_isolation();
    test_mid_reset();
    test_single_beat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_stream_arbiter.md
# pixel_stream_arbiter

Round-robin arbiter that shares one RGB pixel stream output between four requesting RGB streams. Each requester sends bursts (e.g. scanline segments) terminated by a `last` beat. A grant is held for the whole burst, so pixels from different sources never interleave. The block sits upstream of the pixel sink and replaces the static priority select-first mux on that path with a handshaked, fair, burst-locked scheduler that has a registered output.

## Interface
Parameters:
- CH_WIDTH, default 8, width of each colour channel (r, g, b).
- PORT_COUNT is fixed at 4 and is not a parameter.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in1_r / in1_g / in1_b … in4_r / in4_g / in4_b  in  CH_WIDTH each  pixel payload of requester k.
- inK_last  in  1  (K = 1..4) marks the final beat of a burst.
- inK_valid  in  1  requester K has a beat.
- inK_ready  out  1  the arbiter accepts requester K's beat this cycle.
- out_port_r / out_port_g / out_port_b  out  CH_WIDTH each  registered pixel payload.
- out_port_last  out  1  registered last flag.
- out_port_valid  out  1  output beat valid.
- out_port_ready  in  1  the sink accepts the output beat.
- grant  out  4  one-hot index of the owning requester; 0 when idle.

## Operation
- States: IDLE and GRANTED.
- IDLE:
  - `grant` = 0 and all inK_ready = 0.
  - If any inK_valid is set, pick the winner by round-robin. The search starts at the port after `rr_ptr` and wraps 4→1.
  - The winner is registered into `grant` and the FSM moves to GRANTED. `rr_ptr` is set to the winner.
  - With no valid inputs, stay in IDLE.
- GRANTED:
  - The owner's inK_ready = ~out_port_valid | out_port_ready. All other ready signals are 0.
  - On an accepted input beat (inK_valid & inK_ready), load the payload and last flag into the output register and set out_port_valid.
  - An accepted input beat with last = 1 moves the FSM to IDLE and clears `grant` on the next edge. The output register may still hold that beat.
  - If the owner drops valid mid-burst, the grant is held indefinitely. There is no timeout.
- Output register:
  - out_port_valid clears when out_port_ready = 1 and no new beat is loaded in the same cycle.
  - A simultaneous drain and load keeps valid = 1 with the new data.
  - Payload and last hold while out_port_valid = 1 and out_port_ready = 0.
- Non-owner requesters are never given ready. Their data is ignored.
- Reset values:
  - FSM = IDLE.
  - `grant` = 0.
  - `rr_ptr` = port 4, so port 1 has first priority after reset.
  - out_port_valid = 0.
  - out_port_r, out_port_g, out_port_b and out_port_last = 0.
  - All inK_ready = 0.
- Reset asserted mid-burst abandons the burst and returns to the reset state on the next edge. A beat held in the output register is discarded.

## Timing
- Arbitration: a request visible in IDLE at cycle N gives `grant` and inK_ready = 1 in cycle N+1. The first beat is accepted at the N+1 edge and appears on out_port_valid in cycle N+2.
- Steady state: one beat per cycle while out_port_ready = 1. Latency from input to output is exactly 1 cycle.
- Burst turnaround: a last beat accepted at cycle M gives IDLE in M+1, re-arbitration in M+1, and the next grant in M+2. There is exactly one bubble cycle between bursts.
- Backpressure: out_port_ready = 0 with a full register forces inK_ready = 0 in the same cycle. This is a combinational path from out_port_ready to inK_ready.
- Single-beat burst (last = 1 on the first beat): the block occupies GRANTED for exactly one accepted beat.

## Test plan
- Reset then single requester: in2 sends 3 beats with r/g/b = 0x10/0x20/0x30, then 0x11/0x21/0x31, then 0x12/0x22/0x32 with last on the third. Required: grant = 4'b0010 one cycle after valid; the output reproduces the 3 beats in order with 1-cycle latency; grant = 0 after the last beat.
- Fairness: all four requesters continuously send 2-beat bursts. Required: grant sequence 1, 2, 3, 4, 1, …; exactly one idle cycle between bursts; no interleaving.
- Backpressure: out_port_ready toggles 1, 0, 0, 1 mid-burst. Required: payload stable while stalled; inK_ready = 0 whenever the register is full and ready = 0; no beat lost or duplicated.
- Non-owner isolation: in1 owns the grant while in3 holds valid with changing data. Required: in3_ready stays 0; no in3 data reaches the output until in1's last beat; in3 is granted next.
- Mid-burst reset: rst = 1 for 1 cycle during an in4 burst with a stalled output. Required: out_port_valid = 0, grant = 0, all ready = 0 the cycle after; the next arbitration favours port 1.
- Single-beat bursts from in1 and in2 alternating with full output readiness. Required: throughput of 1 beat per 2 cycles; last = 1 on every output beat.
